// File: rtl/counter_display_pkg.sv
// Shared types and constants for the counter display slice:
// converter FSM states and active-low 7-segment patterns {g,f,e,d,c,b,a}.
package counter_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/counter_display_if.sv
// Load/convert handshake between the counter datapath (master)
// and the display reader (slave).
interface counter_display_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    value_in;
  logic                value_ld;
  logic                busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] bcd_out;

  modport master (
    output value_in,
    output value_ld,
    input  busy,
    input  conv_done,
    input  bcd_out
  );

  modport slave (
    input  value_in,
    input  value_ld,
    output busy,
    output conv_done,
    output bcd_out
  );
endinterface

// File: rtl/counter_display_bin2bcd.sv
// Sequential shift-add-3 binary to packed-BCD converter.
// One iteration per clock; result committed only in DONE.
module bin2bcd
  import counter_display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  conv_state_t   state;
  conv_state_t   next_state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0] scratch;
  logic [BW-1:0] adj;
  logic          load;
  logic          step;
  logic          commit;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1))
          next_state = ST_DONE;
      end
      ST_DONE: begin
        commit     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // add-3 correction precedes the shift within the same iteration
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bin_sr  <= '0;
      scratch <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= commit;
      if (load) begin
        bin_sr  <= bin_in;
        scratch <= '0;
        cnt     <= '0;
      end else if (step) begin
        scratch <= {adj[BW-2:0], bin_sr[WIDTH-1]};
        bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
        cnt     <= cnt + 1'b1;
      end
      if (commit)
        bcd <= scratch;
    end
  end

endmodule

// File: rtl/counter_display.sv
// Samples c_out, converts to BCD and scans an active-low 7-seg display.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the leading one.
module counter_display
  import counter_display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  counter_display_if.slave  bus,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [RW-1:0]     ref_cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        nibble;
  logic [DIGITS-1:0] blank;

  bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.value_ld),
    .bin_in (bus.value_in),
    .busy   (bus.busy),
    .done   (bus.conv_done),
    .bcd    (bus.bcd_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      if (idx == IW'(DIGITS - 1)) idx <= '0;
      else                        idx <= idx + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (bus.bcd_out[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  // an and seg are both decoded from idx, so they switch together
  always_comb begin
    nibble = bus.bcd_out[4*int'(idx) +: 4];
    an     = ~(DIGITS'(1) << idx);
    seg    = blank[idx] ? SEG_BLANK : seg_decode(nibble);
  end

endmodule

// File: tb/tb_counter_display.sv
// Directed bench for counter_display with REFRESH_DIV=4.
module tb_counter_display;

  localparam int WIDTH       = 16;
  localparam int DIGITS      = 5;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SB = 7'h7F;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [6:0]        exp_seg [DIGITS];
  logic [4:0]        an_tab [6];

  counter_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  counter_display #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [15:0] v, output int busy_n,
                          output int done_at);
    busy_n  = 0;
    done_at = -1;
    bus.value_in = v;
    bus.value_ld = 1'b1;
    @(negedge clk);
    bus.value_ld = 1'b0;
    bus.value_in = ~v;
    for (int j = 0; j < 40; j++) begin
      if (bus.busy) busy_n++;
      if (bus.conv_done) begin
        done_at = j;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_scan(input string tag);
    logic [DIGITS-1:0] prev;
    logic              synced;
    synced = 1'b0;
    prev   = an;
    for (int i = 0; i < 100 && !synced; i++) begin
      @(negedge clk);
      if (prev == 5'b01111 && an == 5'b11110) synced = 1'b1;
      prev = an;
    end
    check($sformatf("%s sync", tag), 32'(synced), 32'd1);
    for (int d = 0; d < DIGITS; d++) begin
      for (int c = 0; c < REFRESH_DIV; c++) begin
        check($sformatf("%s an d%0d c%0d", tag, d, c), 32'(an),
              32'(an_tab[d]));
        if (c == 0)
          check($sformatf("%s seg d%0d", tag, d), 32'(seg),
                32'(exp_seg[d]));
        @(negedge clk);
      end
    end
    check($sformatf("%s an wrap", tag), 32'(an), 32'(an_tab[5]));
  endtask

  initial begin
    int bn;
    int da;
    int cnt;
    an_tab = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};

    reset        = 1'b1;
    bus.value_ld = 1'b0;
    bus.value_in = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.conv_done), 32'd0);
    check("rst bcd", 32'(bus.bcd_out), 32'h0);
    check("rst an", 32'(an), 32'h1E);
    check("rst seg", 32'(seg), 32'(S0));
    reset = 1'b0;
    @(negedge clk);

    run_conv(16'hFFFF, bn, da);
    check("ffff busy cycles", 32'(bn), 32'd17);
    check("ffff done at", 32'(da), 32'd17);
    check("ffff bcd", 32'(bus.bcd_out), 32'h65535);
    @(negedge clk);
    check("ffff done pulse", 32'(bus.conv_done), 32'd0);

    run_conv(16'd1234, bn, da);
    check("1234 done at", 32'(da), 32'd17);
    check("1234 bcd", 32'(bus.bcd_out), 32'h01234);
    @(negedge clk);
    run_conv(16'd0, bn, da);
    check("0 bcd", 32'(bus.bcd_out), 32'h00000);
    @(negedge clk);

    // load during busy is dropped
    bus.value_in = 16'd4321;
    bus.value_ld = 1'b1;
    @(negedge clk);
    bus.value_ld = 1'b0;
    repeat (5) @(negedge clk);
    bus.value_in = 16'd9;
    bus.value_ld = 1'b1;
    @(negedge clk);
    bus.value_ld = 1'b0;
    da = -1;
    for (int j = 0; j < 40; j++) begin
      if (bus.conv_done) begin
        da = j;
        break;
      end
      @(negedge clk);
    end
    check("busy ld done seen", 32'(da >= 0), 32'd1);
    check("busy ld bcd", 32'(bus.bcd_out), 32'h04321);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy || bus.conv_done) cnt++;
    end
    check("busy ld not queued", 32'(cnt), 32'd0);
    check("busy ld bcd kept", 32'(bus.bcd_out), 32'h04321);

    // load in the DONE cycle is dropped too
    bus.value_in = 16'd777;
    bus.value_ld = 1'b1;
    @(negedge clk);
    bus.value_ld = 1'b0;
    repeat (16) @(negedge clk);
    bus.value_in = 16'd9;
    bus.value_ld = 1'b1;
    @(negedge clk);
    bus.value_ld = 1'b0;
    check("done ld pulse", 32'(bus.conv_done), 32'd1);
    check("done ld bcd", 32'(bus.bcd_out), 32'h00777);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    check("done ld not queued", 32'(cnt), 32'd0);

    run_conv(16'd1234, bn, da);
    check("scan bcd", 32'(bus.bcd_out), 32'h01234);
`ifdef LEADING_ZERO_BLANK_EN
    exp_seg = '{S4, S3, S2, S1, SB};
`else
    exp_seg = '{S4, S3, S2, S1, S0};
`endif
    check_scan("scan1234");

    run_conv(16'd42, bn, da);
    check("42 bcd", 32'(bus.bcd_out), 32'h00042);
`ifdef LEADING_ZERO_BLANK_EN
    exp_seg = '{S2, S4, SB, SB, SB};
`else
    exp_seg = '{S2, S4, S0, S0, S0};
`endif
    check_scan("scan42");

    run_conv(16'd0, bn, da);
`ifdef LEADING_ZERO_BLANK_EN
    exp_seg = '{S0, SB, SB, SB, SB};
`else
    exp_seg = '{S0, S0, S0, S0, S0};
`endif
    check_scan("scan0");

    run_conv(16'd99, bn, da);
    check("99 bcd", 32'(bus.bcd_out), 32'h00099);
    @(negedge clk);

    // reset in the middle of a conversion
    bus.value_in = 16'd12345;
    bus.value_ld = 1'b1;
    @(negedge clk);
    bus.value_ld = 1'b0;
    repeat (8) @(negedge clk);
    check("mid busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid rst busy", 32'(bus.busy), 32'd0);
    check("mid rst done", 32'(bus.conv_done), 32'd0);
    check("mid rst bcd", 32'(bus.bcd_out), 32'h0);
    check("mid rst an", 32'(an), 32'h1E);
    check("mid rst seg", 32'(seg), 32'(S0));
    reset = 1'b0;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.conv_done || bus.busy) cnt++;
    end
    check("mid rst no done", 32'(cnt), 32'd0);
    check("mid rst bcd held", 32'(bus.bcd_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
